pico_control: RTL

- Multi-cycle fetch/execute controller for the pico-MIPS core. It sits directly upstream of the ALU.
- Registers the instruction, drives ALU function code, operand select and register-file write controls, and owns the PC.
- Consumes ALU zero flag (ZF) for conditional branches; accepts an external input word via valid/ready handshake.

---
 rtl/pico_control.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pico_control.sv
// rtl/pico_control.sv - pico-MIPS multi-cycle fetch/execute controller (optional HALT via HALT_INSN_EN)
module pico_control #(
  parameter int N   = 8,
  parameter int PCW = 8,
  parameter int IW  = 18
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic [IW-1:0]  instr,
  input  logic           zf,
  input  logic           in_valid,
  output logic [PCW-1:0] pc,
  output logic [2:0]     func,
  output logic [2:0]     rd_addr,
  output logic [2:0]     rs_addr,
  output logic [N-1:0]   imm,
  output logic           imm_sel,
  output logic           reg_we,
  output logic           wr_sel,
  output logic           in_ready,
  output logic           halted
);

  localparam logic [2:0] RA = 3'd0, RB = 3'd1, RADD = 3'd2, RSUB = 3'd3,
                         RAND = 3'd4, ROR = 3'd5, RXOR = 3'd6, RMLT = 3'd7;

  typedef enum logic [2:0] {FETCH, EXEC, WB, WAIT_IN, HALT} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ir;
  logic            taken;
  logic [3:0]      op;
  logic            is_halt;
  logic            writes;
  logic [PCW-1:0]  pc_nx;

  assign op      = ir[IW-1 -: 4];
  assign rd_addr = ir[IW-5 -: 3];
  assign rs_addr = ir[IW-8 -: 3];
  assign imm     = ir[N-1:0];
  assign writes  = (op >= 4'h1) && (op <= 4'hB);

`ifdef HALT_INSN_EN
  assign is_halt = (op == 4'h0) && (imm == N'(8'hFF));
`else
  assign is_halt = 1'b0;
`endif

  // Branch offsets are relative to the branch's own pc and wrap modulo 2^PCW.
  always_comb begin
    pc_nx = pc + PCW'(1);
    if (op == 4'hE)
      pc_nx = PCW'(imm);
    else if (taken)
      pc_nx = pc + PCW'($signed(imm));
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      state <= FETCH;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   state_nx = EXEC;
      EXEC:    state_nx = (op == 4'hF) ? WAIT_IN : WB;
      WB:      state_nx = is_halt ? HALT : FETCH;
      WAIT_IN: state_nx = in_valid ? FETCH : WAIT_IN;
      HALT:    state_nx = HALT;
      default: state_nx = FETCH;
    endcase
  end

  always_comb begin
    func    = RA;
    imm_sel = 1'b0;
    case (op)
      4'h1: func = RADD;
      4'h2: begin func = RADD; imm_sel = 1'b1; end
      4'h3: func = RSUB;
      4'h4: begin func = RSUB; imm_sel = 1'b1; end
      4'h5: func = RAND;
      4'h6: func = ROR;
      4'h7: func = RXOR;
      4'h8: func = RMLT;
      4'h9: begin func = RMLT; imm_sel = 1'b1; end
      4'hA: begin func = RB; imm_sel = 1'b1; end
      4'hB: func = RB;
      4'hC, 4'hD: func = RSUB;
      default: func = RA;
    endcase
    in_ready = (state == WAIT_IN);
    wr_sel   = (state == WAIT_IN) && in_valid;
    reg_we   = ((state == WB) && writes) || ((state == WAIT_IN) && in_valid);
`ifdef HALT_INSN_EN
    halted   = (state == HALT);
`else
    halted   = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ir    <= '0;
      pc    <= '0;
      taken <= 1'b0;
    end else begin
      case (state)
        FETCH:   ir <= instr;
        EXEC:    taken <= ((op == 4'hC) && zf) || ((op == 4'hD) && !zf);
        WB:      if (!is_halt) pc <= pc_nx;
        WAIT_IN: if (in_valid) pc <= pc + PCW'(1);
        default: ;
      endcase
    end
  end

endmodule
